// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, key map and column helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Moves the single low bit of the column drive one position up, wrapping 3 -> 0.
  function automatic logic [3:0] col_rotate(input logic [3:0] col_n);
    return {col_n[2:0], col_n[3]};
  endfunction

  // Index of the lowest active-low bit; used for the pressed row and the driven column.
  function automatic logic [1:0] first_low(input logic [3:0] v_n);
    return !v_n[0] ? 2'd0 : !v_n[1] ? 2'd1 : !v_n[2] ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/keypad_digit_scanner_if.sv
// keypad_digit_scanner_if: keypad matrix lines plus the digit outputs feeding the display
interface keypad_digit_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_pulse;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n, digit_new, digit_old, key_pulse, key_held
  );

  modport slave (
    output row_n,
    input  col_n, digit_new, digit_old, key_pulse, key_held
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchroniser; resets to all-ones so idle rows read as "no key"
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Shift the asynchronous input through two flops before anyone looks at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= {WIDTH{1'b1}};
      r_s2 <= {WIDTH{1'b1}};
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/keypad_digit_scanner.sv
// keypad_digit_scanner: scans a 4x4 keypad, debounces press/release, keeps the last two hex codes
module keypad_digit_scanner
  import keypad_pkg::*;
#(
  parameter logic [23:0] SCAN_DIV        = 24'd60000,
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1200000
) (
  input  logic                          clk,
  input  logic                          reset,
  keypad_digit_scanner_if.master        bus
);
  state_t      r_state, w_state_nx;
  logic [3:0]  r_col_n, w_col_n_nx;
  logic [23:0] r_dwell, w_dwell_nx;
  logic [23:0] r_db, w_db_nx;
  logic [1:0]  r_row, w_row_nx;
  logic [1:0]  r_col, w_col_nx;
  logic [3:0]  r_digit_new, w_digit_new_nx;
  logic [3:0]  r_digit_old, w_digit_old_nx;
  logic        r_pulse, w_pulse_nx;
  logic [3:0]  w_rs;
  logic        w_row_low;
  logic        w_any_low;
  logic        w_dwell_end;
  logic        w_db_end;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.row_n),
    .o_q   (w_rs)
  );

  assign w_row_low   = !w_rs[r_row];
  assign w_any_low   = !(&w_rs);
  assign w_dwell_end = r_dwell == SCAN_DIV - 24'd1;
  assign w_db_end    = r_db == DEBOUNCE_CYCLES - 24'd1;

  // Next-state logic: every exit back to SCAN advances the column and restarts the dwell.
  always_comb begin
    w_state_nx     = r_state;
    w_col_n_nx     = r_col_n;
    w_dwell_nx     = r_dwell;
    w_db_nx        = r_db;
    w_row_nx       = r_row;
    w_col_nx       = r_col;
    w_digit_new_nx = r_digit_new;
    w_digit_old_nx = r_digit_old;
    w_pulse_nx     = 1'b0;
    case (r_state)
      SCAN: begin
        if (!w_dwell_end) begin
          w_dwell_nx = r_dwell + 24'd1;
        end else if (w_any_low) begin
          w_state_nx = DEBOUNCE;
          w_row_nx   = first_low(w_rs);
          w_col_nx   = first_low(r_col_n);
          w_db_nx    = '0;
          w_dwell_nx = '0;
        end else begin
          w_col_n_nx = col_rotate(r_col_n);
          w_dwell_nx = '0;
        end
      end
      DEBOUNCE: begin
        if (!w_row_low) begin
          w_state_nx = SCAN;
          w_col_n_nx = col_rotate(r_col_n);
          w_dwell_nx = '0;
        end else if (w_db_end) begin
          w_state_nx     = HELD;
          w_digit_old_nx = r_digit_new;
          w_digit_new_nx = KEY_MAP[r_row][r_col];
          w_pulse_nx     = 1'b1;
        end else begin
          w_db_nx = r_db + 24'd1;
        end
      end
      HELD: begin
        if (!w_row_low) begin
          w_state_nx = RELEASE;
          w_db_nx    = '0;
        end
      end
      default: begin
        if (w_row_low) begin
          w_state_nx = HELD;
        end else if (w_db_end) begin
          w_state_nx = SCAN;
          w_col_n_nx = col_rotate(r_col_n);
          w_dwell_nx = '0;
        end else begin
          w_db_nx = r_db + 24'd1;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any press in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_col_n     <= COL_RESET;
      r_dwell     <= '0;
      r_db        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_digit_new <= '0;
      r_digit_old <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_col_n     <= w_col_n_nx;
      r_dwell     <= w_dwell_nx;
      r_db        <= w_db_nx;
      r_row       <= w_row_nx;
      r_col       <= w_col_nx;
      r_digit_new <= w_digit_new_nx;
      r_digit_old <= w_digit_old_nx;
      r_pulse     <= w_pulse_nx;
    end
  end

  assign bus.col_n     = r_col_n;
  assign bus.digit_new = r_digit_new;
  assign bus.digit_old = r_digit_old;
  assign bus.key_pulse = r_pulse;
  assign bus.key_held  = (r_state == HELD) || (r_state == RELEASE);
endmodule

// File: tb/tb_keypad_digit_scanner.sv
// tb_keypad_digit_scanner: keypad-model bench with directed and random presses vs a digit-history model
module tb_keypad_digit_scanner;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] press;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses = 0;
  int          exp_new = 0;
  int          exp_old = 0;
  int          code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0]  seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_digit_scanner_if kif ();

  keypad_digit_scanner #(.SCAN_DIV(24'd4), .DEBOUNCE_CYCLES(24'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif.master)
  );

  always #5 clk = ~clk;

  assign kif.row_n = {~|(press[15:12] & ~kif.col_n), ~|(press[11:8] & ~kif.col_n),
                      ~|(press[7:4] & ~kif.col_n), ~|(press[3:0] & ~kif.col_n)};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Count strobes and require exactly one driven column on every cycle.
  always @(negedge clk) begin
    if (kif.key_pulse) pulses++;
    check("col_onecold", $countones(~kif.col_n), 1);
  end

  task automatic do_press(input int k, input int hold, input int rel);
    int p0;
    p0 = pulses;
    press[k] = 1'b1;
    run(hold);
    exp_old = exp_new;
    exp_new = code_tab[k];
    check("press_pulses", pulses - p0, 1);
    check("press_new", kif.digit_new, exp_new);
    check("press_old", kif.digit_old, exp_old);
    check("press_held", kif.key_held, 1);
    press[k] = 1'b0;
    run(4);
    check("release_still_held", kif.key_held, 1);
    run(rel);
    check("release_done", kif.key_held, 0);
  endtask

  initial begin
    int p0;
    logic [3:0] c0;
    press = '0;
    reset = 1'b1;
    run(3);
    check("rst_col", kif.col_n, 4'b1110);
    check("rst_new", kif.digit_new, 0);
    check("rst_old", kif.digit_old, 0);
    check("rst_pulse", kif.key_pulse, 0);
    check("rst_held", kif.key_held, 0);
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      check("idle_col", kif.col_n, seq[(i / 4) % 4]);
      tick();
    end

    do_press(6, 40, 16);
    c0 = kif.col_n;
    run(4);
    check("scan_resumes", kif.col_n != c0, 1);

    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      press[0] = ~press[0];
      run(3);
    end
    press[0] = 1'b0;
    run(3);
    check("bounce_no_pulse", pulses - p0, 0);
    do_press(0, 40, 20);
    check("bounce_new", kif.digit_new, 1);

    p0 = pulses;
    do_press(2, 40, 20);
    do_press(11, 40, 20);
    check("seq_old", kif.digit_old, 3);
    check("seq_new", kif.digit_new, 12);
    check("seq_pulses", pulses - p0, 2);

    p0 = pulses;
    press[9] = 1'b1;
    run(40);
    press[13] = 1'b1;
    run(20);
    press[13] = 1'b0;
    run(5);
    press[9] = 1'b0;
    run(2);
    press[9] = 1'b1;
    run(20);
    exp_old = exp_new;
    exp_new = 8;
    check("multi_pulses", pulses - p0, 1);
    check("multi_new", kif.digit_new, 8);
    check("multi_old", kif.digit_old, exp_old);
    check("glitch_held", kif.key_held, 1);
    press[9] = 1'b0;
    run(20);
    check("multi_release", kif.key_held, 0);

    reset = 1'b1;
    run(2);
    reset = 1'b0;
    p0 = pulses;
    press[4] = 1'b1;
    run(9);
    reset = 1'b1;
    press[4] = 1'b0;
    run(2);
    check("midrst_col", kif.col_n, 4'b1110);
    check("midrst_new", kif.digit_new, 0);
    check("midrst_old", kif.digit_old, 0);
    check("midrst_held", kif.key_held, 0);
    reset = 1'b0;
    run(10);
    check("midrst_no_pulse", pulses - p0, 0);
    exp_new = 0;
    exp_old = 0;

    for (int i = 0; i < 8; i++)
      do_press($urandom_range(0, 15), $urandom_range(40, 60), $urandom_range(20, 30));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
